decoder_3_8_hold: RTL and testbench
===================================

Name: decoder_3_8_hold

Overview:
- Sequential 3-to-8 decoder. Accepts 3-bit switch codes (plus "code meaningful" flag) from the 8-3 priority-encoder path over a valid/ready handshake.
- Buffers up to DEPTH codes in a small FIFO and replays each as a one-hot 8-bit pattern, held for HOLD_CYCLES clocks, with GAP_CYCLES of blank output between patterns.
- Sits between the encoder stage and the LED/display driver so that every code is visible for a fixed time.

Parameters:
HOLD_CYCLES, 4, clocks each decoded pattern is held on y (>=1)
GAP_CYCLES, 1, clocks of all-zero output between consecutive patterns (>=0)
DEPTH, 2, input FIFO entries (power of two, >=2)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
en  input  1  block enable; low flushes and idles the block
in_valid  input  1  producer offers in_code/in_nz
in_ready  output  1  block can accept; transfer when in_valid && in_ready at rising edge
in_code  input  3  encoded switch index 0..7
in_nz  input  1  1 = code meaningful; 0 = "no input active", decodes to all-zero pattern
y  output  8  registered one-hot decoded pattern (or 0)
y_valid  output  1  1 while a pattern (including an all-zero in_nz=0 pattern) is being held
busy  output  1  state != IDLE or FIFO non-empty
level  output  clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (rst=1 at edge): y=0, y_valid=0, level=0, state=IDLE, counters=0. FIFO contents are discarded. in_ready=0 during the reset cycle and =en after.
- rst has priority over en. en has priority over all other activity.
- en=0 at edge: FIFO flushed (level=0), state=IDLE, y=0, y_valid=0. in_ready is combinational: en && (level < DEPTH), derived from registered level only. No same-cycle pass-through when full, even if a pop occurs that edge.
- Push: on accept, {in_nz,in_code} is written at the write pointer. Pointers wrap modulo DEPTH. Simultaneous push and pop: level unchanged, both pointers advance.
- Pop/load: y <= in_nz ? (8'b1 << in_code) : 8'h00; y_valid <= 1; hold counter <= HOLD_CYCLES-1; state <= SHOW.
- IDLE: y=0, y_valid=0. If level>0, pop/load.
- Latency: code accepted at edge N into an empty FIFO with block in IDLE -> y/y_valid updated at edge N+1.
- SHOW: y and y_valid held; counter decrements each edge. When counter==0 at an edge:
  - GAP_CYCLES>0: y<=0, y_valid<=0, gap counter<=GAP_CYCLES-1, state<=GAP.
  - GAP_CYCLES==0 and level>0: pop/load immediately (back-to-back, y changes directly to next pattern).
  - Otherwise: y<=0, y_valid<=0, state<=IDLE.
- Each pattern is therefore visible exactly HOLD_CYCLES clocks.
- GAP: y=0, y_valid=0; counter decrements. When counter==0: pop/load if level>0, else IDLE. Exactly GAP_CYCLES blank clocks.
- Counters sized clog2 of the largest of HOLD_CYCLES/GAP_CYCLES, minimum 1 bit; no overflow possible.
- busy = (state != IDLE) || (level != 0), combinational from registers.
- Input data is sampled only on accept; in_code/in_nz changes while in_ready=0 have no effect.

Test Plan (HOLD_CYCLES=4, GAP_CYCLES=1, DEPTH=2):
- Reset: hold rst 2 cycles with in_valid=1 -> y=00, y_valid=0, level=0, in_ready=0 during reset and 1 after.
- Single code: accept code=5, nz=1 at edge N -> y=0x20, y_valid=1 for edges N+1..N+4; y=0, y_valid=0 at N+5; IDLE, busy=0 after.
- nz=0: accept code=3, nz=0 -> y=0x00 with y_valid=1 for 4 clocks.
- Back-pressure: offer 7, 0, 2, 6 on consecutive cycles with in_valid held -> in_ready drops when level=2. Output sequence 0x80, 0x01, 0x04, 0x40, each 4 clocks with a 1-clock zero gap; no code lost or duplicated.
- GAP_CYCLES=0 rebuild: two queued codes 1, 4 -> y goes 0x02 for 4 clocks, then directly 0x10 for 4 clocks.
- en drop: with level=2 and state SHOW, en=0 for one edge -> next cycle y=0, y_valid=0, level=0, busy=0, in_ready=0 while en low. Re-enable and accept code 2 -> 0x04 shown normally.

Source files
------------

// File: rtl/decoder_3_8_hold.sv
// Sequential 3-to-8 decoder: queues encoder codes in a small FIFO and replays
// each as a one-hot pattern held for HOLD_CYCLES clocks, separated by GAP_CYCLES blank clocks.
module decoder_3_8_hold #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int DEPTH       = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2:0]                   in_code,
  input  logic                         in_nz,
  output logic [7:0]                   y,
  output logic                         y_valid,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int LVL_W   = $clog2(DEPTH + 1);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [LVL_W-1:0] FULL      = LVL_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    GAP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [3:0]       mem [DEPTH];
  logic             push;
  logic             pop;
  logic [3:0]       head;
  logic [7:0]       head_pat;

  // Ready looks only at the registered level, so a pop on a full FIFO never
  // opens a same-cycle slot.
  assign in_ready = en && !rst && (level < FULL);
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr];
  assign head_pat = head[3] ? (8'b1 << head[2:0]) : 8'h00;
  assign busy     = (state != IDLE) || (level != '0);

  always_comb begin
    // NOTE: default first so every path assigns pop and no latch is inferred.
    pop = 1'b0;
    if (en && !rst && (level != '0)) begin
      case (state)
        IDLE:    pop = 1'b1;
        SHOW:    pop = (cnt == '0) && (GAP_CYCLES == 0);
        GAP:     pop = (cnt == '0);
        default: pop = 1'b0;
      endcase
    end
  end

  // NOTE: storage is not reset; a flush only clears pointers and level, so stale
  // entries are unreachable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_nz, in_code};
  end

  // NOTE: all state here uses non-blocking assignments so every register sees
  // the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state   <= IDLE;
      cnt     <= '0;
      y       <= 8'h00;
      y_valid <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level + LVL_W'(push) - LVL_W'(pop);

      if (pop) begin
        y       <= head_pat;
        y_valid <= 1'b1;
        cnt     <= HOLD_LOAD;
        state   <= SHOW;
      end else begin
        case (state)
          IDLE: begin
            y       <= 8'h00;
            y_valid <= 1'b0;
          end
          SHOW: begin
            if (cnt == '0) begin
              y       <= 8'h00;
              y_valid <= 1'b0;
              if (GAP_CYCLES > 0) begin
                cnt   <= GAP_LOAD;
                state <= GAP;
              end else begin
                state <= IDLE;
              end
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          GAP: begin
            if (cnt == '0) state <= IDLE;
            else           cnt   <= cnt - CNT_W'(1);
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decoder_3_8_hold.sv
// Bench for decoder_3_8_hold: two instances (GAP_CYCLES=1 and 0) share stimulus and are
// compared every cycle against a schedule model, plus literal spot checks.
module tb_decoder_3_8_hold;

  localparam int HOLD  = 4;
  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst, en, in_valid, in_nz;
  logic [2:0] in_code;

  logic [7:0] y_a, y_b;
  logic       yv_a, yv_b, busy_a, busy_b, rdy_a, rdy_b;
  logic [1:0] lvl_a, lvl_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decoder_3_8_hold #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(1), .DEPTH(DEPTH)) dut_a (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(rdy_a),
    .in_code(in_code), .in_nz(in_nz), .y(y_a), .y_valid(yv_a), .busy(busy_a), .level(lvl_a)
  );

  decoder_3_8_hold #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(0), .DEPTH(DEPTH)) dut_b (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(rdy_b),
    .in_code(in_code), .in_nz(in_nz), .y(y_b), .y_valid(yv_b), .busy(busy_b), .level(lvl_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Schedule model: each accepted code gets a start edge
  // max(accept+1, previous start + HOLD + gap) and is visible for HOLD edges from there.
  int         gap_of [2] = '{1, 0};
  int         q_start [2][4];
  logic [7:0] q_pat [2][4];
  int         mcnt [2];
  int         cur_start [2];
  logic [7:0] cur_pat [2];
  int         last_sched [2];
  int         edge_no = 0;
  int         last_e = 0;
  bit         started = 0;

  task automatic model_edge(input int m, input int e);
    bit acc;
    int st;
    if (rst || !en) begin
      mcnt[m] = 0;
      cur_start[m] = -1000;
      last_sched[m] = -1000;
      return;
    end
    acc = in_valid && (mcnt[m] < DEPTH);
    if (mcnt[m] > 0 && q_start[m][0] == e) begin
      cur_start[m] = e;
      cur_pat[m] = q_pat[m][0];
      for (int i = 0; i < 3; i++) begin
        q_start[m][i] = q_start[m][i+1];
        q_pat[m][i] = q_pat[m][i+1];
      end
      mcnt[m]--;
    end
    if (acc) begin
      st = last_sched[m] + HOLD + gap_of[m];
      if (e + 1 > st) st = e + 1;
      q_start[m][mcnt[m]] = st;
      q_pat[m][mcnt[m]] = in_nz ? 8'(1 << in_code) : 8'h00;
      last_sched[m] = st;
      mcnt[m]++;
    end
  endtask

  always @(posedge clk) begin
    model_edge(0, edge_no);
    model_edge(1, edge_no);
    last_e = edge_no;
    edge_no++;
    started = 1;
  end

  task automatic compare_one(input int m, input logic [7:0] y, input logic yv,
                             input logic bz, input logic [1:0] lv, input logic rd);
    int    d;
    bit    show;
    string t;
    d = last_e - cur_start[m];
    show = (d < HOLD);
    t = (m == 0) ? "a" : "b";
    check({t, ".y"}, 32'(y), show ? 32'(cur_pat[m]) : 32'h0);
    check({t, ".y_valid"}, 32'(yv), 32'(show));
    check({t, ".busy"}, 32'(bz), 32'((mcnt[m] > 0) || (d < HOLD + gap_of[m])));
    check({t, ".level"}, 32'(lv), 32'(mcnt[m]));
    check({t, ".in_ready"}, 32'(rd), 32'(!rst && en && (mcnt[m] < DEPTH)));
  endtask

  logic [7:0] seen [$];
  bit         rec_on = 0;
  logic       prev_yv_a = 1'b0;

  always @(negedge clk) begin
    if (started) begin
      compare_one(0, y_a, yv_a, busy_a, lvl_a, rdy_a);
      compare_one(1, y_b, yv_b, busy_b, lvl_b, rdy_b);
      if (rec_on && yv_a && !prev_yv_a) seen.push_back(y_a);
      prev_yv_a = yv_a;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] bp_codes [4] = '{3'd7, 3'd0, 3'd2, 3'd6};
  logic [7:0] bp_exp   [4] = '{8'h80, 8'h01, 8'h04, 8'h40};

  initial begin
    bit acc;
    bit stalled;
    rst = 1'b1; en = 1'b1; in_valid = 1'b1; in_code = 3'd5; in_nz = 1'b1;

    // Reset with in_valid asserted
    tick(); tick();
    check("rst.in_ready", 32'(rdy_a), 32'h0);
    check("rst.y", 32'(y_a), 32'h0);
    check("rst.y_valid", 32'(yv_a), 32'h0);
    check("rst.level", 32'(lvl_a), 32'h0);
    rst = 1'b0; in_valid = 1'b0;
    #1 check("rst.in_ready_after", 32'(rdy_a), 32'h1);

    // Single code 5
    in_valid = 1'b1; in_code = 3'd5; in_nz = 1'b1;
    tick();
    in_valid = 1'b0;
    check("one.y_latency", 32'(yv_a), 32'h0);
    check("one.level", 32'(lvl_a), 32'h1);
    for (int k = 0; k < HOLD; k++) begin
      tick();
      check("one.y", 32'(y_a), 32'h20);
      check("one.y_valid", 32'(yv_a), 32'h1);
    end
    tick();
    check("one.y_end", 32'(y_a), 32'h0);
    check("one.y_valid_end", 32'(yv_a), 32'h0);
    tick();
    check("one.busy_idle", 32'(busy_a), 32'h0);

    // nz=0 gives a held all-zero pattern
    in_valid = 1'b1; in_code = 3'd3; in_nz = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < HOLD; k++) begin
      tick();
      check("nz0.y", 32'(y_a), 32'h0);
      check("nz0.y_valid", 32'(yv_a), 32'h1);
    end
    tick();
    check("nz0.y_valid_end", 32'(yv_a), 32'h0);
    repeat (3) tick();

    // Back-pressure: producer holds each code until instance a accepts it
    seen.delete();
    rec_on = 1;
    stalled = 0;
    in_valid = 1'b1; in_nz = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_code = bp_codes[i];
      acc = 0;
      for (int k = 0; k < 50 && !acc; k++) begin
        @(negedge clk);
        acc = rdy_a;
        if (!rdy_a) stalled = 1;
        tick();
      end
      if (!acc) check("bp.accept_timeout", 32'h0, 32'h1);
    end
    in_valid = 1'b0;
    repeat (40) tick();
    rec_on = 0;
    check("bp.stalled", 32'(stalled), 32'h1);
    check("bp.count", 32'(seen.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < seen.size()) check("bp.seq", 32'(seen[i]), 32'(bp_exp[i]));

    // Back-to-back on the GAP_CYCLES=0 instance: 1 then 4
    in_valid = 1'b1; in_nz = 1'b1; in_code = 3'd1;
    tick();
    in_code = 3'd4;
    tick();
    in_valid = 1'b0;
    check("g0.y_first", 32'(y_b), 32'h02);
    for (int k = 0; k < HOLD - 1; k++) begin
      tick();
      check("g0.y_first", 32'(y_b), 32'h02);
    end
    for (int k = 0; k < HOLD; k++) begin
      tick();
      check("g0.y_second", 32'(y_b), 32'h10);
      check("g0.y_valid", 32'(yv_b), 32'h1);
    end
    tick();
    check("g0.y_end", 32'(y_b), 32'h0);
    repeat (20) tick();

    // en drop while showing with a full FIFO
    in_valid = 1'b1; in_code = 3'd1;
    tick();
    in_code = 3'd2;
    tick();
    in_code = 3'd3;
    tick();
    in_valid = 1'b0;
    check("en.level_full", 32'(lvl_a), 32'h2);
    check("en.showing", 32'(yv_a), 32'h1);
    en = 1'b0;
    tick();
    check("en.y", 32'(y_a), 32'h0);
    check("en.y_valid", 32'(yv_a), 32'h0);
    check("en.level", 32'(lvl_a), 32'h0);
    check("en.busy", 32'(busy_a), 32'h0);
    check("en.in_ready", 32'(rdy_a), 32'h0);
    en = 1'b1;
    tick();
    in_valid = 1'b1; in_code = 3'd2;
    tick();
    in_valid = 1'b0;
    tick();
    check("en.reload_y", 32'(y_a), 32'h04);
    check("en.reload_valid", 32'(yv_a), 32'h1);
    repeat (10) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
